// File: rtl/countdown_timer_if.sv
// Load handshake bundle for countdown_timer.
//   load_valid  master -> slave  load request
//   load_value  master -> slave  value to load (WIDTH bits)
//   load_ready  slave  -> master high while the timer can accept a load
interface countdown_timer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with load handshake, start/pause/abort
// control, optional auto-reload and a one-cycle registered expiry pulse.
//   clk     rising-edge clock
//   res     synchronous active-high reset
//   ld      load handshake (countdown_timer_if slave modport)
//   start   begin counting, sampled only while a value is loaded
//   pause   level input, freezes counting while high
//   abort   return to IDLE from any state, clearing the count
//   reload  auto-reload enable, sampled at each expiry
//   y       current count (registered)
//   busy    high while counting or paused
//   done    one-cycle expiry pulse (registered)
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             res,
  countdown_timer_if.slave ld,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             reload,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, LOADED, RUN, PAUSE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] y_n;
  logic [WIDTH-1:0] preset, preset_n;
  logic [PC_W-1:0]  pc, pc_n;
  logic             done_n;
  logic             count_en;

  assign ld.load_ready = (state == IDLE) || (state == LOADED);
  assign busy          = (state == RUN)  || (state == PAUSE);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    y_n      = y;
    preset_n = preset;
    pc_n     = pc;
    done_n   = 1'b0;
    count_en = 1'b0;

    if (abort && state != IDLE) begin
      state_n = IDLE;
      y_n     = '0;
      pc_n    = '0;
    end else begin
      unique case (state)
        IDLE, LOADED: begin
          // A load always wins over a start sampled in the same cycle.
          if (ld.load_valid) begin
            y_n      = ld.load_value;
            preset_n = ld.load_value;
            state_n  = LOADED;
          end else if (state == LOADED && start) begin
            if (y != '0) begin
              state_n = RUN;
              pc_n    = '0;
            end else begin
              // Zero load expires immediately; the count never wraps.
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end
        RUN: begin
          if (pause) state_n = PAUSE;
          else       count_en = 1'b1;
        end
        PAUSE: begin
          // The resume cycle counts, so each cycle with pause high delays
          // expiry by exactly one cycle.
          if (!pause) begin
            state_n  = RUN;
            count_en = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (count_en) begin
      if (pc != PC_LAST) begin
        pc_n = pc + 1'b1;
      end else begin
        pc_n = '0;
        if (y > WIDTH'(1)) begin
          y_n = y - WIDTH'(1);
        end else begin
          done_n = 1'b1;
          if (reload) begin
            y_n = preset;
          end else begin
            y_n     = '0;
            state_n = IDLE;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      y      <= '0;
      preset <= '0;
      pc     <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      y      <= y_n;
      preset <= preset_n;
      pc     <= pc_n;
      done   <= done_n;
    end
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, prescaled down-counter with an explicit load handshake, start/pause/abort control, an optional auto-reload mode and a one-cycle expiry pulse. It is the decrementing counterpart to the team's free-running up-counter. It serves as the timeout and interval generator for control blocks in the same clock domain.

## Interface

Parameters:
- WIDTH, 8, width of the count and load value.
- PRESCALE, 1, clock cycles per decrement. Legal range is ≥1.

Ports:
- clk  in  1  rising-edge clock.
- res  in  1  reset. Synchronous, active-high. One clock; all state is updated only on the rising edge of clk.
- load_valid  in  1  load request.
- load_ready  out  1  load accepted when high. Combinational; high in IDLE and LOADED.
- load_value  in  WIDTH  value to load.
- start  in  1  begin counting. Sampled in LOADED only.
- pause  in  1  level input; freezes counting while high in RUN.
- abort  in  1  return to IDLE from any state.
- reload  in  1  auto-reload enable. Sampled at each expiry.
- y  out  WIDTH  current count. Registered.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  one-cycle expiry pulse. Registered.

## Operation

States: IDLE, LOADED, RUN, PAUSE. Internal registers: `preset` (WIDTH bits) and prescale counter `pc` (range 0..PRESCALE-1).

Reset (res=1 at an edge), which has the highest priority:
- y=0, preset=0, pc=0, state=IDLE, done=0.
- Resulting outputs: busy=0, load_ready=1.

Global behaviour:
- abort has next priority. In any state other than IDLE it forces y=0, pc=0, state=IDLE, done=0.
- abort in IDLE has no effect.

IDLE and LOADED:
- A load transfer occurs when load_valid && load_ready: y<=load_value, preset<=load_value, state<=LOADED.
- A transfer in LOADED overwrites the pending value.

LOADED with start=1:
- If the load and start are sampled together, the load wins; start is ignored that cycle.
- If y≠0: state<=RUN, pc<=0.
- If y==0: done<=1, state<=IDLE. There is no wrap to the maximum value.

RUN, in priority order:
- pause=1: state<=PAUSE. pc and y hold.
- Otherwise, if pc≠PRESCALE-1: pc<=pc+1.
- Otherwise, a tick occurs: pc<=0, and then:
  - If y>1: y<=y-1.
  - If y==1 and reload=0: y<=0, done<=1, state<=IDLE.
  - If y==1 and reload=1: y<=preset, done<=1, state stays RUN.

PAUSE:
- pause=0: state<=RUN. Counting resumes from the frozen pc.

Arithmetic and load rules:
- Decrement is modulo-free: y never goes below 0 and never wraps.
- load_valid with load_ready=0 (RUN or PAUSE) is ignored, not queued.

## Timing

- done is low in every cycle except the single cycle following the expiry edge.
- Latency with start sampled at edge E0 and value N≥1:
  - Decrements occur at edges E0+P, E0+2P, …, where P=PRESCALE.
  - Expiry occurs at edge E0+N·P. In non-reload mode, y=0, done=1 and busy=0 all appear after that same edge.
- Each pause cycle in RUN or PAUSE delays expiry by exactly one cycle.
- busy rises the cycle after start is accepted and falls the cycle after expiry or abort.
- In reload mode the period is N·P cycles. done pulses once per period while y shows preset.
- Simultaneous events:
  - res beats everything.
  - abort beats pause, tick and load.
  - pause in the same cycle as a pending tick: the tick is suppressed and happens after resume.

## Test plan

- Reset mid-RUN (load 200, run 10 cycles, res=1 for one edge) -> y=0, state IDLE, busy=0, done=0, load_ready=1, and no done pulse afterward.
- PRESCALE=1, load 5, start -> y=5,4,3,2,1,0 on consecutive cycles. done=1 only in the y=0 cycle; busy falls the same cycle.
- PRESCALE=1, load 3, reload=1, start -> y=3,2,1,3,2,1,…; done pulses every 3 cycles. Dropping reload before expiry ends at y=0 with state IDLE.
- PRESCALE=4, load 2, pause held 10 cycles after the first tick -> expiry at start+8+10 cycles, with y unchanged during the pause.
- In RUN, load_valid=1 with load_value=99 -> load_ready=0 and y unaffected. Then abort while in PAUSE -> y=0, IDLE, no done.
- Load 0, then start -> done pulse next cycle, y stays 0 (no 255), busy never rises.
